// File: rtl/ats21_cmd_deserializer.sv
// ATS21 command deserializer: rebuilds 32-bit client words from two 16-bit beats,
// queues pre-decoded commands, and hands them to the core. Option macro: ATS21_RSVD_FILTER_EN.
module ats21_cmd_deserializer #(
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_client,
  output logic [31:0] cmd_word,
  output logic [2:0]  cmd_opcode,
  output logic [4:0]  cmd_id,
  output logic [3:0]  cmd_clock,
  output logic        cmd_flag,
  output logic        err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WORD2 = 1'b1;

  // ready needs room for a full A+B pair, so the fill level must leave two slots
  localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(FIFO_DEPTH - 2);

  logic [0:0]      state_q, state_d;
  logic [15:0]     up_a_q, up_a_d;
  logic [15:0]     up_b_q, up_b_d;
  logic            va_q, va_d;
  logic            vb_q, vb_d;
  logic            drop_b_q, drop_b_d;

  logic [32:0]     mem_q [FIFO_DEPTH];
  logic [32:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;

  logic            out_valid_q, out_valid_d;
  logic [32:0]     out_entry_q, out_entry_d;

  logic [PTR_W:0]  fill;
  logic [PTR_W:0]  avail;
  logic            pop;
  logic            ready_int;
  logic            rsvd_b;
  logic [PTR_W-1:0] wr_idx_a;
  logic [PTR_W-1:0] wr_idx_b;

  assign fill      = wr_ptr_q - rd_ptr_q;
  assign pop       = out_valid_q & cmd_ready;
  assign ready_int = (state_q == ST_IDLE) && (fill <= READY_MAX);
  assign ready     = ready_int;

`ifdef ATS21_RSVD_FILTER_EN
  // mode and reserved opcodes are only honoured from client A
  assign rsvd_b = (ctrlB[15:13] == 3'b100) || (ctrlB[15:13] == 3'b011);
`else
  assign rsvd_b = 1'b0;
`endif

  assign wr_idx_a = wr_ptr_q[PTR_W-1:0];
  assign wr_idx_b = wr_ptr_q[PTR_W-1:0] + {{(PTR_W-1){1'b0}}, va_q};

  always_comb begin
    state_d  = state_q;
    up_a_d   = up_a_q;
    up_b_d   = up_b_q;
    va_d     = va_q;
    vb_d     = vb_q;
    drop_b_d = drop_b_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (state_q == ST_IDLE) begin
      if (req && ready_int) begin
        up_a_d   = ctrlA;
        up_b_d   = ctrlB;
        va_d     = (ctrlA[15:13] != 3'b000);
        vb_d     = (ctrlB[15:13] != 3'b000) && !rsvd_b;
        drop_b_d = rsvd_b;
        state_d  = ST_WORD2;
      end
    end else begin
      // lower words are captured regardless of req; a stray req here is only flagged
      state_d = ST_IDLE;
      if (va_q) begin
        mem_d[wr_idx_a] = {1'b0, up_a_q, ctrlA};
      end
      if (vb_q) begin
        mem_d[wr_idx_b] = {1'b1, up_b_q, ctrlB};
      end
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, va_q} + {{PTR_W{1'b0}}, vb_q};
    end
  end

  // Output stage sees only entries that existed before this edge, adding one cycle of latency
  always_comb begin
    rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    avail       = fill - {{PTR_W{1'b0}}, pop};
    out_valid_d = (avail != '0);
    out_entry_d = out_valid_d ? mem_q[rd_ptr_d[PTR_W-1:0]] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      up_a_q      <= '0;
      up_b_q      <= '0;
      va_q        <= 1'b0;
      vb_q        <= 1'b0;
      drop_b_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      up_a_q      <= up_a_d;
      up_b_q      <= up_b_d;
      va_q        <= va_d;
      vb_q        <= vb_d;
      drop_b_q    <= drop_b_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    err = 1'b0;
    if (state_q == ST_IDLE) begin
      err = req && !ready_int;
    end else begin
      err = req || drop_b_q;
    end
  end

  assign cmd_valid  = out_valid_q;
  assign cmd_client = out_entry_q[32];
  assign cmd_word   = out_entry_q[31:0];
  assign cmd_opcode = out_entry_q[31:29];
  assign cmd_id     = out_entry_q[28:24];
  assign cmd_flag   = out_entry_q[23];

  always_comb begin
    case (out_entry_q[31:29])
      3'b001, 3'b010: cmd_clock = out_entry_q[28:25];
      3'b101, 3'b110: cmd_clock = out_entry_q[19:16];
      default:        cmd_clock = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_ats21_cmd_deserializer.sv
// Bench for ats21_cmd_deserializer: queue-based reference model checked every cycle,
// plus literal expectations on the popped command log for each directed scenario.
module tb_ats21_cmd_deserializer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [15:0] ctrlA, ctrlB;
  logic        ready, cmd_valid, cmd_ready, cmd_client, cmd_flag, err;
  logic [31:0] cmd_word;
  logic [2:0]  cmd_opcode;
  logic [4:0]  cmd_id;
  logic [3:0]  cmd_clock;

  ats21_cmd_deserializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_client(cmd_client), .cmd_word(cmd_word), .cmd_opcode(cmd_opcode),
    .cmd_id(cmd_id), .cmd_clock(cmd_clock), .cmd_flag(cmd_flag), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        client;
    logic [31:0] word;
  } ent_t;

  typedef struct packed {
    logic        client;
    logic [31:0] word;
    logic [2:0]  opcode;
    logic [4:0]  id;
    logic [3:0]  clock;
    logic        flag;
  } obs_t;

  ent_t        m_q[$];
  obs_t        obs_q[$];
  bit          m_idle = 1'b1;
  bit          m_vis  = 1'b0;
  bit          m_dropb = 1'b0;
  logic [15:0] m_up_a, m_up_b;

  function automatic logic [3:0] exp_clock(input logic [31:0] w);
    if (w[31:29] == 3'd1 || w[31:29] == 3'd2) return w[28:25];
    if (w[31:29] == 3'd5 || w[31:29] == 3'd6) return w[19:16];
    return 4'd0;
  endfunction

  function automatic bit b_is_filtered(input logic [2:0] op);
`ifdef ATS21_RSVD_FILTER_EN
    return (op == 3'd4) || (op == 3'd3);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: a queue of whole commands, visible at the head one edge after push
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_q.delete();
      m_idle  = 1'b1;
      m_vis   = 1'b0;
      m_dropb = 1'b0;
    end else begin
      bit rdy;
      rdy = m_idle && ((DEPTH - m_q.size()) >= 2);
      if (m_vis && cmd_ready && m_q.size() > 0) void'(m_q.pop_front());
      m_vis = (m_q.size() != 0);
      if (!m_idle) begin
        if (m_up_a[15:13] != 3'd0) m_q.push_back('{1'b0, {m_up_a, ctrlA}});
        if (m_up_b[15:13] != 3'd0 && !m_dropb) m_q.push_back('{1'b1, {m_up_b, ctrlB}});
        m_idle = 1'b1;
      end else if (req && rdy) begin
        m_up_a  = ctrlA;
        m_up_b  = ctrlB;
        m_dropb = b_is_filtered(ctrlB[15:13]);
        m_idle  = 1'b0;
      end
    end
  end

  initial forever begin
    bit exp_ready, exp_err;
    @(negedge clk);
    exp_ready = m_idle && ((DEPTH - m_q.size()) >= 2);
    exp_err   = m_idle ? (req && !exp_ready) : (req || m_dropb);
    check("ready", ready, exp_ready);
    check("err", err, exp_err);
    check("cmd_valid", cmd_valid, m_vis);
    if (m_vis && m_q.size() > 0) begin
      check("cmd_client", cmd_client, m_q[0].client);
      check("cmd_word", cmd_word, m_q[0].word);
      check("cmd_opcode", cmd_opcode, m_q[0].word[31:29]);
      check("cmd_id", cmd_id, m_q[0].word[28:24]);
      check("cmd_clock", cmd_clock, exp_clock(m_q[0].word));
      check("cmd_flag", cmd_flag, m_q[0].word[23]);
    end
    if (cmd_valid && cmd_ready)
      obs_q.push_back('{cmd_client, cmd_word, cmd_opcode, cmd_id, cmd_clock, cmd_flag});
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit hold2);
    @(posedge clk); #1;
    req = 1'b1; ctrlA = a[31:16]; ctrlB = b[31:16];
    @(posedge clk); #1;
    req = hold2; ctrlA = a[15:0]; ctrlB = b[15:0];
  endtask

  task automatic quiet();
    @(posedge clk); #1;
    req = 1'b0; ctrlA = 16'h0; ctrlB = 16'h0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (m_idle && m_q.size() == 0 && !m_vis) begin
        done = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: queue size %0d, expected 0", m_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req = 1'b0; ctrlA = 16'h0; ctrlB = 16'h0; cmd_ready = 1'b1;

    // 1: reset values held throughout reset and at release
    repeat (4) begin
      @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_valid", cmd_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_word", cmd_word, 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", ready, 1'b1);
    check("rel_valid", cmd_valid, 1'b0);

    // 2: dual command, A then B
    obs_q.delete();
    send(32'h2000_0000, 32'h2240_0000, 1'b0);
    quiet();
    drain();
    check("t2_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("t2_a_word", obs_q[0].word, 32'h2000_0000);
      check("t2_a_client", obs_q[0].client, 1'b0);
      check("t2_a_clock", obs_q[0].clock, 4'd0);
      check("t2_b_client", obs_q[1].client, 1'b1);
      check("t2_b_clock", obs_q[1].clock, 4'd1);
      check("t2_b_mult", obs_q[1].word[23:22], 2'b01);
    end

    // 3: A only, B is a Nop
    obs_q.delete();
    send(32'hA080_0025, 32'h0000_1234, 1'b0);
    quiet();
    drain();
    check("t3_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("t3_opcode", obs_q[0].opcode, 3'b101);
      check("t3_id", obs_q[0].id, 5'd0);
      check("t3_flag", obs_q[0].flag, 1'b1);
      check("t3_clock", obs_q[0].clock, 4'd0);
      check("t3_value", obs_q[0].word[15:0], 16'h0025);
    end

    // 4: countdown
    obs_q.delete();
    send(32'hC102_0010, 32'h0000_0000, 1'b0);
    quiet();
    drain();
    check("t4_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("t4_id", obs_q[0].id, 5'd1);
      check("t4_clock", obs_q[0].clock, 4'd2);
      check("t4_value", obs_q[0].word[15:0], 16'h0010);
    end

    // 5: back-pressure fills the FIFO; third request is dropped
    obs_q.delete();
    cmd_ready = 1'b0;
    send(32'h2000_0001, 32'h2240_0002, 1'b0);
    send(32'hA080_0003, 32'hC102_0004, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; ctrlA = 16'h2000; ctrlB = 16'h2000;
    @(negedge clk);
    check("t5_ready_low", ready, 1'b0);
    check("t5_drop_err", err, 1'b1);
    quiet();
    repeat (3) @(posedge clk);
    #1 cmd_ready = 1'b1;
    drain();
    check("t5_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("t5_a0", obs_q[0].word, 32'h2000_0001);
      check("t5_b0", obs_q[1].word, 32'h2240_0002);
      check("t5_a1", obs_q[2].word, 32'hA080_0003);
      check("t5_b1", obs_q[3].word, 32'hC102_0004);
      check("t5_b1_client", obs_q[3].client, 1'b1);
    end

    // 6: req held two cycles; B carries reserved opcode 100
    obs_q.delete();
    send(32'h0000_0000, 32'h8000_0000, 1'b1);
    @(negedge clk);
    check("t6_err", err, 1'b1);
    quiet();
    drain();
`ifdef ATS21_RSVD_FILTER_EN
    check("t6_count", obs_q.size(), 0);
`else
    check("t6_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("t6_opcode", obs_q[0].opcode, 3'b100);
      check("t6_client", obs_q[0].client, 1'b1);
      check("t6_word", obs_q[0].word, 32'h8000_0000);
    end
`endif

    // 7: reset mid-transfer discards queued commands
    obs_q.delete();
    cmd_ready = 1'b0;
    send(32'h2000_0007, 32'h2240_0008, 1'b0);
    quiet();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t7_valid", cmd_valid, 1'b0);
    check("t7_ready", ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    cmd_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t7_none", obs_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ats21_cmd_deserializer.md
Name: ats21_cmd_deserializer

Overview:
Front-end stage of ATS21, directly downstream of the client pins (req/ctrlA/ctrlB) and upstream of the ATS21 command core. It reassembles each client's two 16-bit words into one 32-bit instruction and pre-decodes the fields. Decoded commands are queued in a small FIFO and handed to the core over a valid/ready handshake, client A first. Pin-level `ready` back-pressures the clients.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 4.
PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width; derived, not overridden.

Ports:
clk  in  1  single clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
req  in  1  first-word strobe from the client pins.
ctrlA  in  16  client A word: upper half on the req cycle, lower half on the following cycle.
ctrlB  in  16  client B word: same timing as ctrlA.
ready  out  1  high = a new req will be accepted.
cmd_valid  out  1  FIFO head is valid.
cmd_ready  in  1  core accepts the head this cycle.
cmd_client  out  1  0 = A, 1 = B.
cmd_word  out  32  full instruction {upper, lower}.
cmd_opcode  out  3  cmd_word[31:29].
cmd_id  out  5  alarm/timer number, cmd_word[28:24].
cmd_clock  out  4  clock number: cmd_word[28:25] for opcodes 001/010, cmd_word[19:16] for 101/110, else 0.
cmd_flag  out  1  enable/repeat bit, cmd_word[23].
err  out  1  one-cycle pulse on a protocol error or dropped command.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFO emptied; FSM forced to IDLE; capture registers cleared.
  - Outputs: ready = 1, cmd_valid = 0, err = 0, all cmd_* outputs = 0.
- Reset asserted mid-capture or mid-transfer discards every partial and queued command.
- FSM states: IDLE, WORD2.
  - IDLE, req = 1, ready = 1:
    - latch ctrlA and ctrlB as upper words.
    - vA = (ctrlA[15:13] != 000); vB = (ctrlB[15:13] != 000). Opcode 000 is a Nop and is not a command.
    - go to WORD2.
  - IDLE, req = 1, ready = 0: request dropped, err pulses, stay in IDLE.
  - WORD2: latch ctrlA and ctrlB as lower words, then push into the FIFO in the same edge: A entry if vA, B entry if vB, with A at the lower slot. Return to IDLE.
  - WORD2, req = 1: protocol violation. The second word is still captured as lower data, req is ignored, err pulses.
- Back-to-back instructions: req may next be high on the cycle after WORD2, giving a 2-cycle minimum spacing.
- ready = (FSM == IDLE) and (free entries >= 2).
  - Because of this, a two-entry push can never overflow the FIFO.
  - ready falls in WORD2 and rises on the cycle after free entries reach 2.
- Latency: the last word arrives on edge N; cmd_valid rises after edge N+1 (registered FIFO output). If the FIFO was empty, B's entry follows A's on the next accepted pop.
- Pop: on cmd_valid & cmd_ready the head advances. Push and pop in the same cycle are both honoured. Count arithmetic is wrap-around modulo FIFO_DEPTH using an extra pointer MSB.
- cmd_ready while cmd_valid = 0: no effect.
- cmd_* outputs hold stable while cmd_valid = 1 and cmd_ready = 0.
- Opcode 100 (reserved): behaviour set by the optional feature below.

Optional Feature:
Macro ATS21_RSVD_FILTER_EN.
- Defined: a word with opcode 100 or 011 (mode), arriving from client B, is not pushed, and err pulses in the WORD2 cycle. Mode changes are restricted to client A.
- Undefined: every non-Nop word is pushed unmodified; err is driven only by protocol and overflow errors.

Test Plan:
1. Reset held low for 4 cycles, then released → ready = 1, cmd_valid = 0, err = 0 throughout the reset and on release.
2. req with A = 0x2000_0000 and B = 0x2240_0000 (set clock 1 to 2X), cmd_ready = 1 → two pops in order:
   - A: cmd_word 0x20000000, cmd_clock 0.
   - B: cmd_client = 1, cmd_clock 1, cmd_word[23:22] = 01.
3. A = 0xA080_0025, B = Nop → exactly one entry: cmd_opcode 101, cmd_id 0, cmd_flag 1, cmd_clock 0, cmd_word[15:0] = 0x0025.
4. A = 0xC102_0010 (countdown) → cmd_id 1, cmd_clock 2, value 0x0010.
5. cmd_ready held 0 while sending dual commands every 2 cycles with FIFO_DEPTH = 4:
   - after 2 instructions, ready = 0;
   - a third req pulses err and is dropped;
   - after cmd_ready releases, the 4 entries drain in order A0, B0, A1, B1.
6. req held high for 2 cycles → err pulses once and the second cycle is captured as lower words. With ATS21_RSVD_FILTER_EN defined, B = 0x8000_0000 → no push and err = 1; without it → pushed with cmd_opcode 100.
